chan_merge: RTL and testbench

//  Inverse of the ADC channel splitter: takes paired channel-A/channel-B samples and
//  re-serialises them into one interleaved stream A0,B0,A1,B1,... on a single clock.

---
 rtl/chan_merge.sv | 131 +++++++++++++
 tb/tb_chan_merge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_merge.sv
// chan_merge: re-serialises paired channel-A/channel-B samples into a single
// interleaved stream A0,B0,A1,B1,... through a small pair FIFO.
// Optional build macro CHAN_MERGE_TAG_EN adds a registered chan_o output
// (0 = data_o carries an A sample, 1 = a B sample).
//
// Handshake: a pair is written when valid_i && ready_o; a sample leaves when
// valid_o && ready_i. data_o/valid_o are held stable while valid_o && !ready_i.
// ready_o depends on registered FIFO state only, never on ready_i.
module chan_merge #(
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic [DW-1:0] data_a_i,
    input  logic [DW-1:0] data_b_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          overflow_o,
`ifdef CHAN_MERGE_TAG_EN
    output logic          chan_o,
`endif
    output logic          dbg_phase
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_t;

    phase_t          phase;
    phase_t          phase_nxt;

    logic [DW-1:0]   mem_a [FIFO_DEPTH];
    logic [DW-1:0]   mem_b [FIFO_DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            full;
    logic            empty;
    logic            wr_en;
    logic            load;
    logic            pop;
    logic [DW-1:0]   head_a;
    logic [DW-1:0]   head_b;

    // Pointer-based full/empty: an extra MSB distinguishes full from empty.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign ready_o = !full;
    assign wr_en   = valid_i && !full;
    assign head_a  = mem_a[rd_ptr[AW-1:0]];
    assign head_b  = mem_b[rd_ptr[AW-1:0]];

    // Output register may take a new word when it is empty or being consumed.
    assign load      = (!valid_o || ready_i) && !empty;
    assign dbg_phase = phase;

    // Pair storage; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_a[wr_ptr[AW-1:0]] <= data_a_i;
            mem_b[wr_ptr[AW-1:0]] <= data_b_i;
        end
    end

    // Write and read pointers; both may advance in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Phase state register (which half of the head pair goes out next).
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) phase <= PH_A;
        else        phase <= phase_nxt;
    end

    // Phase next-state: A leaves the entry in place, B releases it.
    always_comb begin
        phase_nxt = phase;
        pop       = 1'b0;
        case (phase)
            PH_A: if (load) phase_nxt = PH_B;
            PH_B: begin
                if (load) begin
                    phase_nxt = PH_A;
                    pop       = 1'b1;
                end
            end
            default: phase_nxt = PH_A;
        endcase
    end

    // Registered output word; drops valid once consumed with nothing to refill.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (load) begin
            data_o  <= (phase == PH_A) ? head_a : head_b;
            valid_o <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

`ifdef CHAN_MERGE_TAG_EN
    // Channel tag follows data_o: 0 for A, 1 for B.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)    chan_o <= 1'b0;
        else if (load) chan_o <= (phase == PH_B);
    end
`endif

    // Sticky overflow: a pair offered while full is dropped and flagged.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                overflow_o <= 1'b0;
        else if (valid_i && full)  overflow_o <= 1'b1;
    end

endmodule

// File: tb/tb_chan_merge.sv
// tb_chan_merge: directed table, multi-cycle sequences and a randomized run
// against a word-queue reference model of chan_merge.
module tb_chan_merge;

    localparam int DW    = 12;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_a_i = '0;
    logic [DW-1:0] data_b_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic          overflow_o;
    logic          dbg_phase;
`ifdef CHAN_MERGE_TAG_EN
    logic          chan_o;
`endif

    chan_merge #(.DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .data_a_i   (data_a_i),
        .data_b_i   (data_b_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .overflow_o (overflow_o),
`ifdef CHAN_MERGE_TAG_EN
        .chan_o     (chan_o),
`endif
        .dbg_phase  (dbg_phase)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: queue of words accepted but not yet presented,
    // plus the word currently presented on the output.
    logic [DW-1:0] exp_q[$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ovf;
    logic          m_chan;
    int            m_loaded;

    // Pairs still occupying the FIFO: a pair stays until its B word leaves.
    function automatic int m_pairs();
        return (exp_q.size() + 1) / 2;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_valid  = 1'b0;
        m_data   = '0;
        m_ovf    = 1'b0;
        m_chan   = 1'b0;
        m_loaded = 0;
    endtask

    // Reset the DUT and check the reset state while rst_n is low.
    task automatic do_reset();
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        data_a_i = '0;
        data_b_i = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_ovf", overflow_o, 1'b0);
        chk("rst_data", data_o, '0);
        chk("rst_phase", dbg_phase, 1'b0);
`ifdef CHAN_MERGE_TAG_EN
        chk("rst_chan", chan_o, 1'b0);
`endif
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock against the model; called at a negedge, returns at the next.
    task automatic cycle(input logic vin, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic rdy);
        logic acc;
        logic load;
        valid_i  = vin;
        data_a_i = a;
        data_b_i = b;
        ready_i  = rdy;
        chk("ready", ready_o, (m_pairs() < DEPTH));
        acc  = vin && (m_pairs() < DEPTH);
        if (vin && !acc) m_ovf = 1'b1;
        load = (!m_valid || rdy) && (exp_q.size() > 0);
        if (load) begin
            m_data  = exp_q.pop_front();
            m_chan  = m_loaded[0];
            m_loaded++;
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (acc) begin
            exp_q.push_back(a);
            exp_q.push_back(b);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        chk("valid", valid_o, m_valid);
        if (m_valid) begin
            chk("data", data_o, m_data);
`ifdef CHAN_MERGE_TAG_EN
            chk("chan", chan_o, m_chan);
`endif
        end
        chk("ovf", overflow_o, m_ovf);
    endtask

    typedef struct {
        logic          vin;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          rdy;
        logic          exp_vo;
        logic [DW-1:0] exp_d;
        logic          exp_rdyo;
        logic          exp_ovf;
    } vec_t;

    vec_t vec_q[$];

    task automatic add_row(input logic vin, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic rdy, input logic evo, input logic [DW-1:0] ed,
                           input logic erdy, input logic eovf);
        vec_t v;
        v.vin = vin; v.a = a; v.b = b; v.rdy = rdy;
        v.exp_vo = evo; v.exp_d = ed; v.exp_rdyo = erdy; v.exp_ovf = eovf;
        vec_q.push_back(v);
    endtask

    initial begin
        int n;
        int run;
        int max_run;
        logic vin;
        logic rdy;
        logic acc_pred;
        logic saw_full;

        // Single pair latency, then fill to full, overflow, refused write on pop, drain.
        add_row(1, 12'h123, 12'h456, 1, 0, 12'h000, 1, 0);
        add_row(0, 12'h000, 12'h000, 1, 1, 12'h123, 1, 0);
        add_row(0, 12'h000, 12'h000, 1, 1, 12'h456, 1, 0);
        add_row(0, 12'h000, 12'h000, 1, 0, 12'h456, 1, 0);
        add_row(1, 12'h011, 12'h811, 0, 0, 12'h456, 1, 0);
        add_row(1, 12'h022, 12'h822, 0, 1, 12'h011, 1, 0);
        add_row(1, 12'h033, 12'h833, 0, 1, 12'h011, 1, 0);
        add_row(1, 12'h044, 12'h844, 0, 1, 12'h011, 0, 0);
        add_row(1, 12'h055, 12'h855, 0, 1, 12'h011, 0, 1);
        add_row(1, 12'h066, 12'h866, 1, 1, 12'h811, 1, 1);
        add_row(0, 12'h000, 12'h000, 1, 1, 12'h022, 1, 1);
        add_row(0, 12'h000, 12'h000, 1, 1, 12'h822, 1, 1);
        add_row(0, 12'h000, 12'h000, 1, 1, 12'h033, 1, 1);
        add_row(0, 12'h000, 12'h000, 1, 1, 12'h833, 1, 1);
        add_row(0, 12'h000, 12'h000, 1, 1, 12'h044, 1, 1);
        add_row(0, 12'h000, 12'h000, 1, 1, 12'h844, 1, 1);
        add_row(0, 12'h000, 12'h000, 1, 0, 12'h844, 1, 1);

        do_reset();
        for (int i = 0; i < vec_q.size(); i++) begin
            valid_i  = vec_q[i].vin;
            data_a_i = vec_q[i].a;
            data_b_i = vec_q[i].b;
            ready_i  = vec_q[i].rdy;
            @(posedge clk_i);
            @(negedge clk_i);
            chk($sformatf("tbl%0d_valid", i), valid_o, vec_q[i].exp_vo);
            chk($sformatf("tbl%0d_data", i), data_o, vec_q[i].exp_d);
            chk($sformatf("tbl%0d_ready", i), ready_o, vec_q[i].exp_rdyo);
            chk($sformatf("tbl%0d_ovf", i), overflow_o, vec_q[i].exp_ovf);
        end

        // Back-to-back 8 pairs with ready_i high: 16 consecutive words.
        do_reset();
        n = 0; run = 0; max_run = 0;
        for (int c = 0; c < 60; c++) begin
            if (n == 8 && exp_q.size() == 0 && !m_valid) break;
            vin = (n < 8);
            acc_pred = vin && (m_pairs() < DEPTH);
            cycle(vin, DW'(n), DW'(12'h800 | n), 1'b1);
            if (acc_pred) n++;
            if (valid_o) run++;
            else run = 0;
            if (run > max_run) max_run = run;
        end
        chk("b2b_pairs", n, 8);
        chk("b2b_run", max_run, 16);
        chk("b2b_drained", exp_q.size(), 0);

        // Downstream stall of 20 cycles mid-stream.
        do_reset();
        n = 0; saw_full = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (n == 8 && exp_q.size() == 0 && !m_valid) break;
            rdy = !(c >= 4 && c < 24);
            vin = (n < 8) && (m_pairs() < DEPTH);
            cycle(vin, DW'(12'h100 + n), DW'(12'h900 + n), rdy);
            if (vin) n++;
            if (!ready_o) saw_full = 1'b1;
        end
        chk("stall_pairs", n, 8);
        chk("stall_full_seen", saw_full, 1'b1);
        chk("stall_drained", exp_q.size(), 0);

        // Asynchronous reset mid-stream with a held word and overflow set.
        do_reset();
        for (int c = 0; c < 6; c++) cycle(1'b1, DW'(12'h200 + c), DW'(12'hA00 + c), 1'b0);
        chk("pre_rst_ovf", overflow_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", valid_o, 1'b0);
        chk("async_rst_ready", ready_o, 1'b1);
        chk("async_rst_ovf", overflow_o, 1'b0);
        @(negedge clk_i);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (m_pairs() < DEPTH) vin = 1'($urandom_range(0, 1));
            else                   vin = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            cycle(vin, DW'($urandom), DW'($urandom), rdy);
        end
        for (int c = 0; c < 20; c++) cycle(1'b0, '0, '0, 1'b1);
        chk("rand_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
